// File: rtl/rr_arb2_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb2_pkg
// Shared definitions for the two-channel round-robin packet arbiter:
//   - state_t       : arbiter FSM states (IDLE, LOCK0, LOCK1)
//   - CH0 / CH1     : channel identifiers, also the value driven on sel
//   - DEFAULT_WIDTH : default data bits per beat
// ---------------------------------------------------------------------------
package rr_arb2_pkg;

    localparam int   DEFAULT_WIDTH = 8;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2_pkt_mux2to1.sv
// ---------------------------------------------------------------------------
// mux2to1
// Single-bit 2:1 select cell used to build the arbiter's steering datapath.
// Ports:
//   a   in  1  selected when sel = 0
//   b   in  1  selected when sel = 1
//   sel in  1  select
//   y   out 1  selected value
// ---------------------------------------------------------------------------
module mux2to1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/rr_arb2_pkt.sv
// ---------------------------------------------------------------------------
// rr_arb2_pkt
// Two-channel round-robin packet arbiter feeding one registered output
// stream. A grant is held from the first beat of a packet until the beat
// carrying last is accepted; priority then alternates to the other channel.
// Ports:
//   clk, rst                         clock and synchronous active-high reset
//   in0_valid/in0_data/in0_last      channel 0 beat
//   in0_ready                        channel 0 accept
//   in1_valid/in1_data/in1_last      channel 1 beat
//   in1_ready                        channel 1 accept
//   out_valid/out_data/out_last      registered output beat
//   out_sel                          channel ID of the registered beat
//   out_ready                        downstream accept
// ---------------------------------------------------------------------------
module rr_arb2_pkt
    import rr_arb2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_sel,
    input  logic             out_ready
);

    state_t         state;
    state_t         state_next;
    logic           prio;
    logic           prio_next;
    logic           grant;
    logic           slot_free;
    logic           accept;
    logic [WIDTH:0] mux_a;
    logic [WIDTH:0] mux_b;
    logic [WIDTH:0] mux_y;

    // The output register can take a new beat when it is empty or is being
    // drained in this same cycle, which is what allows 1 beat/cycle.
    assign slot_free = !out_valid || out_ready;

    // Grant selection. In IDLE a lone valid channel wins outright and a tie
    // goes to the priority pointer; once locked the grant never moves, even
    // if the owning channel drops valid between beats.
    always_comb begin
        grant = CH0;
        case (state)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    grant = prio;
                end else if (in1_valid) begin
                    grant = CH1;
                end else begin
                    grant = CH0;
                end
            end
            LOCK0:   grant = CH0;
            LOCK1:   grant = CH1;
            default: grant = CH0;
        endcase
    end

    assign in0_ready = (grant == CH0) && slot_free && !rst;
    assign in1_ready = (grant == CH1) && slot_free && !rst;
    assign accept    = (in0_valid && in0_ready) || (in1_valid && in1_ready);

    // Steering datapath: bit WIDTH carries last, the rest carry data.
    assign mux_a = {in0_last, in0_data};
    assign mux_b = {in1_last, in1_data};

    for (genvar i = 0; i <= WIDTH; i++) begin : g_mux
        mux2to1 u_mux (
            .a   (mux_a[i]),
            .b   (mux_b[i]),
            .sel (grant),
            .y   (mux_y[i])
        );
    end

    // Next-state logic. A last beat closes the packet and hands priority to
    // the other channel; any other accepted beat locks onto its channel.
    always_comb begin
        state_next = state;
        prio_next  = prio;
        if (accept) begin
            if (mux_y[WIDTH]) begin
                state_next = IDLE;
                prio_next  = ~grant;
            end else begin
                state_next = (grant == CH1) ? LOCK1 : LOCK0;
            end
        end
    end

    // State, priority pointer and output register. Reset abandons any
    // partially forwarded packet; a new beat takes precedence over draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= CH0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= CH0;
        end else begin
            state <= state_next;
            prio  <= prio_next;
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= mux_y[WIDTH-1:0];
                out_last  <= mux_y[WIDTH];
                out_sel   <= grant;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
